// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory / MMIO responder.
// Holds the MMIO register offsets, the STATUS bit layout and the TOHOST pass code.
package dmem_pkg;

    localparam logic [3:0] OFS_TOHOST  = 4'h0;
    localparam logic [3:0] OFS_CONSOLE = 4'h4;
    localparam logic [3:0] OFS_CYCLE   = 4'h8;
    localparam logic [3:0] OFS_STATUS  = 4'hC;

    localparam int ST_OVF   = 8;
    localparam int ST_FULL  = 7;
    localparam int ST_EMPTY = 6;
    localparam int ST_CNT_W = 5;

    localparam logic [31:0] TOHOST_PASS = 32'd1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wen;
    } dmem_req_t;

    function automatic logic [31:0] status_word(input logic ovf, input logic full,
                                                input logic empty, input logic [ST_CNT_W-1:0] cnt);
        logic [31:0] s;
        s              = '0;
        s[ST_OVF]      = ovf;
        s[ST_FULL]     = full;
        s[ST_EMPTY]    = empty;
        s[ST_CNT_W-1:0] = cnt;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with sticky overflow; head is shown combinationally.
// A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic             overflow
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             push_ok, pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // DEPTH is a power of two, so pointer wrap is the natural overflow of AW bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)      count <= count + 1'b1;
            else if (pop_ok && !push_ok) count <= count - 1'b1;
            if (push && !push_ok)        overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/dmem_mmio_responder.sv
// CPU data-port responder: byte-lane word RAM with combinational reads plus a
// 16-byte MMIO window (TOHOST, console FIFO, cycle counter, status).
module dmem_mmio_responder
    import dmem_pkg::*;
#(
    parameter int          MEM_WORDS  = 1024,
    parameter logic [31:0] MMIO_BASE  = 32'h0000_1000,
    parameter int          CON_DEPTH  = 8,
    // Reset value of the cycle counter; nonzero only to reach the wrap point quickly.
    parameter logic [31:0] CYCLE_INIT = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] d_mem_addr,
    input  logic [31:0] d_mem_wdata,
    input  logic [3:0]  d_mem_wen,
    output logic [31:0] d_mem_rdata,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready,
    output logic        done,
    output logic        pass,
    output logic [31:0] tohost_val,
    output logic        err_sticky
);

    localparam int IW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(CON_DEPTH) + 1;

    dmem_req_t     req;
    logic          ram_hit, mmio_hit, wr;
    logic [3:0]    ofs;
    logic [IW-1:0] ram_idx;
    logic [31:0]   ram [MEM_WORDS];
    logic [31:0]   cycle;
    logic          con_push, con_pop, con_full, con_empty, con_ovf;
    logic [CW-1:0] con_count;
    logic          unused_bits;

    assign req         = '{addr: d_mem_addr, wdata: d_mem_wdata, wen: d_mem_wen};
    assign unused_bits = ^req.addr[1:0];

    assign ram_hit  = (req.addr[31:2] < 30'(MEM_WORDS));
    assign mmio_hit = (req.addr[31:4] == MMIO_BASE[31:4]);
    assign ofs      = {req.addr[3:2], 2'b00};
    assign ram_idx  = req.addr[IW+1:2];
    assign wr       = rst_n && (req.wen != 4'b0000);

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr && ram_hit && req.wen[i]) ram[ram_idx][8*i +: 8] <= req.wdata[8*i +: 8];
        end
    end

    assign con_push  = wr && mmio_hit && (ofs == OFS_CONSOLE) && req.wen[0];
    assign con_pop   = con_valid && con_ready;
    assign con_valid = !con_empty;

    sync_fifo #(.WIDTH(8), .DEPTH(CON_DEPTH)) u_con_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (con_push),
        .wdata    (req.wdata[7:0]),
        .pop      (con_pop),
        .rdata    (con_data),
        .full     (con_full),
        .empty    (con_empty),
        .count    (con_count),
        .overflow (con_ovf)
    );

    // TOHOST latches only the first nonzero write; later writes are ignored until reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done       <= 1'b0;
            pass       <= 1'b0;
            tohost_val <= '0;
        end else if (wr && mmio_hit && (ofs == OFS_TOHOST) && !done && (req.wdata != '0)) begin
            done       <= 1'b1;
            pass       <= (req.wdata == TOHOST_PASS);
            tohost_val <= req.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
            cycle      <= CYCLE_INIT;
        end else begin
            if (wr && !ram_hit && !mmio_hit) err_sticky <= 1'b1;
            cycle <= cycle + 32'd1;
        end
    end

    always_comb begin
        d_mem_rdata = '0;
        if (ram_hit) begin
            d_mem_rdata = ram[ram_idx];
        end else if (mmio_hit) begin
            case (ofs)
                OFS_TOHOST: d_mem_rdata = tohost_val;
                OFS_CYCLE:  d_mem_rdata = cycle;
                OFS_STATUS: d_mem_rdata = status_word(con_ovf, con_full, con_empty,
                                                      ST_CNT_W'(con_count));
                default:    d_mem_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Bench for dmem_mmio_responder: a queue/array reference model checked every cycle,
// plus directed sequences with hand-computed literal expectations.
module tb_dmem_mmio_responder;

    localparam int          MEM_WORDS = 1024;
    localparam logic [31:0] MMIO_BASE = 32'h0000_1000;
    localparam int          DEPTH     = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] d_mem_addr, d_mem_wdata, d_mem_rdata;
    logic [3:0]  d_mem_wen;
    logic        con_valid, con_ready, done, pass, err_sticky;
    logic [7:0]  con_data;
    logic [31:0] tohost_val;

    // second instance only observes the cycle counter wrap
    logic [31:0] addr2, rdata2, tohost2;
    logic        cv2, done2, pass2, err2;
    logic [7:0]  cd2;

    always #5 clk = ~clk;

    dmem_mmio_responder #(.MEM_WORDS(MEM_WORDS), .MMIO_BASE(MMIO_BASE), .CON_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .d_mem_addr(d_mem_addr), .d_mem_wdata(d_mem_wdata),
        .d_mem_wen(d_mem_wen), .d_mem_rdata(d_mem_rdata), .con_valid(con_valid),
        .con_data(con_data), .con_ready(con_ready), .done(done), .pass(pass),
        .tohost_val(tohost_val), .err_sticky(err_sticky));

    dmem_mmio_responder #(.MEM_WORDS(MEM_WORDS), .MMIO_BASE(MMIO_BASE), .CON_DEPTH(DEPTH),
                          .CYCLE_INIT(32'hFFFF_FFFE)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .d_mem_addr(addr2), .d_mem_wdata(32'h0),
        .d_mem_wen(4'h0), .d_mem_rdata(rdata2), .con_valid(cv2), .con_data(cd2),
        .con_ready(1'b0), .done(done2), .pass(pass2), .tohost_val(tohost2), .err_sticky(err2));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] ram_m   [MEM_WORDS];
    logic [3:0]  known_m [MEM_WORDS];
    logic [7:0]  q[$];
    logic        ovf_m, done_m, pass_m, err_m;
    logic [31:0] toh_m, cyc_m;
    bit          minit = 0;

    initial for (int i = 0; i < MEM_WORDS; i++) known_m[i] = 4'h0;

    function automatic bit in_ram(input logic [31:0] a);
        return a < 32'(4 * MEM_WORDS);
    endfunction
    function automatic bit in_mmio(input logic [31:0] a);
        return a >= MMIO_BASE && a < MMIO_BASE + 32'd16;
    endfunction

    always @(posedge clk) begin : model
        bit pop, push;
        int idx;
        if (!rst_n) begin
            q.delete();
            ovf_m = 0; done_m = 0; pass_m = 0; err_m = 0; toh_m = 0; cyc_m = 0;
            minit = 1;
        end else begin
            pop  = (q.size() != 0) && con_ready;
            push = in_mmio(d_mem_addr) && (d_mem_addr[3:2] == 2'd1) && d_mem_wen[0];
            if (pop) void'(q.pop_front());
            if (push) begin
                if (q.size() < DEPTH) q.push_back(d_mem_wdata[7:0]);
                else ovf_m = 1;
            end
            if (d_mem_wen != 0) begin
                if (in_ram(d_mem_addr)) begin
                    idx = int'(d_mem_addr >> 2);
                    for (int b = 0; b < 4; b++)
                        if (d_mem_wen[b]) begin
                            ram_m[idx][8*b +: 8] = d_mem_wdata[8*b +: 8];
                            known_m[idx][b] = 1'b1;
                        end
                end else if (in_mmio(d_mem_addr)) begin
                    if (d_mem_addr[3:2] == 2'd0 && !done_m && d_mem_wdata != 0) begin
                        done_m = 1; pass_m = (d_mem_wdata == 32'd1); toh_m = d_mem_wdata;
                    end
                end else begin
                    err_m = 1;
                end
            end
            cyc_m = cyc_m + 1;
        end
    end

    function automatic logic [31:0] exp_rdata(input logic [31:0] a, output logic [31:0] mask);
        int idx;
        mask = 32'hFFFF_FFFF;
        if (in_ram(a)) begin
            idx = int'(a >> 2);
            for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{known_m[idx][b]}};
            return ram_m[idx];
        end
        if (in_mmio(a)) begin
            case (a[3:2])
                2'd0: return toh_m;
                2'd2: return cyc_m;
                2'd3: return (32'(ovf_m) << 8) | (32'(q.size() == DEPTH) << 7) |
                             (32'(q.size() == 0) << 6) | 32'(q.size());
                default: return 32'h0;
            endcase
        end
        return 32'h0;
    endfunction

    logic [7:0] dut_out[$];

    always @(negedge clk) begin : compare
        logic [31:0] e, m;
        if (minit) begin
            e = exp_rdata(d_mem_addr, m);
            if (m != 0) chk("rdata", d_mem_rdata & m, e & m);
            chk("con_valid", 32'(con_valid), 32'(q.size() != 0));
            chk("con_data", 32'(con_data), (q.size() != 0) ? 32'(q[0]) : 32'h0);
            chk("done", 32'(done), 32'(done_m));
            chk("pass", 32'(pass), 32'(pass_m));
            chk("tohost_val", tohost_val, toh_m);
            chk("err_sticky", 32'(err_sticky), 32'(err_m));
            if (con_valid && con_ready) dut_out.push_back(con_data);
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        d_mem_addr = a; d_mem_wdata = d; d_mem_wen = we;
        @(posedge clk); #1;
        d_mem_wen = 4'h0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
    endtask

    task automatic chk_drain(input string name, input logic [7:0] exp[$]);
        chk({name, "_len"}, 32'(dut_out.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < dut_out.size(); i++)
            chk(name, 32'(dut_out[i]), 32'(exp[i]));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        logic [7:0] exp_bytes[$];
        rst_n = 1'b0; con_ready = 1'b0;
        d_mem_addr = MMIO_BASE + 32'h8; d_mem_wdata = 0; d_mem_wen = 0;
        addr2 = MMIO_BASE + 32'h8;
        idle(2);
        rst_n = 1'b1;

        // cycle counter wrap on the second instance
        @(negedge clk); chk("cycle_wrap0", rdata2, 32'hFFFF_FFFE);
        @(negedge clk); chk("cycle_wrap1", rdata2, 32'hFFFF_FFFF);
        @(negedge clk); chk("cycle_wrap2", rdata2, 32'h0000_0000);
        @(posedge clk); #1;

        // byte-lane merge and same-cycle old-data read
        wr(32'h10, 32'hDEAD_BEEF, 4'b1111);
        wr(32'h10, 32'h0000_00AA, 4'b0001);
        d_mem_addr = 32'h10; d_mem_wdata = 32'h1122_3344; d_mem_wen = 4'b1111;
        @(negedge clk); chk("lane_merge", d_mem_rdata, 32'hDEAD_BEAA);
        @(posedge clk); #1; d_mem_wen = 0;
        @(negedge clk); chk("after_write", d_mem_rdata, 32'h1122_3344);
        @(posedge clk); #1;
        wr(32'h14, 32'hA1B2_C3D4, 4'b1111);
        wr(32'h14, 32'h5566_7788, 4'b0110);
        d_mem_addr = 32'h14;
        @(negedge clk); chk("lane_mid", d_mem_rdata, 32'hA166_77D4);
        @(posedge clk); #1;

        // console fill past capacity, then drain
        for (int i = 0; i < 9; i++) wr(MMIO_BASE + 32'h4, 32'h41 + i, 4'b0001);
        wr(MMIO_BASE + 32'h4, 32'h77, 4'b0010);
        d_mem_addr = MMIO_BASE + 32'hC;
        @(negedge clk);
        chk("status_full_ovf", d_mem_rdata, 32'h0000_0188);
        chk("con_head", 32'(con_data), 32'h41);
        @(posedge clk); #1;
        dut_out.delete(); con_ready = 1'b1;
        idle(10);
        con_ready = 1'b0;
        exp_bytes.delete();
        for (int i = 0; i < 8; i++) exp_bytes.push_back(8'(8'h41 + i));
        chk_drain("drain1", exp_bytes);
        @(negedge clk);
        chk("status_drained", d_mem_rdata, 32'h0000_0140);
        chk("con_valid_empty", 32'(con_valid), 32'h0);
        @(posedge clk); #1;

        // push and pop on a full FIFO in the same cycle
        do_reset();
        for (int i = 0; i < 8; i++) wr(MMIO_BASE + 32'h4, 32'h50 + i, 4'b0001);
        dut_out.delete();
        d_mem_addr = MMIO_BASE + 32'h4; d_mem_wdata = 32'h5A; d_mem_wen = 4'b0001; con_ready = 1'b1;
        @(posedge clk); #1;
        d_mem_wen = 0; con_ready = 1'b0; d_mem_addr = MMIO_BASE + 32'hC;
        @(negedge clk); chk("status_pushpop_full", d_mem_rdata, 32'h0000_0088);
        @(posedge clk); #1;
        con_ready = 1'b1;
        idle(10);
        con_ready = 1'b0;
        exp_bytes.delete();
        for (int i = 0; i < 8; i++) exp_bytes.push_back(8'(8'h50 + i));
        exp_bytes.push_back(8'h5A);
        chk_drain("drain2", exp_bytes);

        // read-only MMIO writes, RAM top word, unmapped write
        do_reset();
        wr(MMIO_BASE + 32'h8, 32'h5, 4'b1111);
        wr(MMIO_BASE + 32'hC, 32'h5, 4'b1111);
        wr(32'h0000_0FFC, 32'hA5A5_0FFC, 4'b1111);
        wr(32'h20, 32'h1, 4'b1111);
        d_mem_addr = 32'h0000_0FFC;
        @(negedge clk);
        chk("ro_write_no_err", 32'(err_sticky), 32'h0);
        chk("ram_top_word", d_mem_rdata, 32'hA5A5_0FFC);
        @(posedge clk); #1;
        d_mem_addr = MMIO_BASE + 32'h10;
        @(negedge clk); chk("past_window_read", d_mem_rdata, 32'h0);
        @(posedge clk); #1;
        wr(32'h8000_0000, 32'h1234_5678, 4'b1111);
        d_mem_addr = 32'h8000_0000;
        @(negedge clk);
        chk("unmapped_err", 32'(err_sticky), 32'h1);
        chk("unmapped_read", d_mem_rdata, 32'h0);
        idle(3);
        @(negedge clk); chk("err_sticky_hold", 32'(err_sticky), 32'h1);
        @(posedge clk); #1;

        // writes during reset are ignored
        rst_n = 1'b0; d_mem_addr = 32'h20; d_mem_wdata = 32'hCAFE_F00D; d_mem_wen = 4'b1111;
        idle(2);
        d_mem_wen = 0; rst_n = 1'b1;
        @(negedge clk);
        chk("reset_write_ignored", d_mem_rdata, 32'h1);
        chk("reset_err_clear", 32'(err_sticky), 32'h0);
        @(posedge clk); #1;

        // TOHOST: zero ignored, first nonzero latched, later ignored
        wr(MMIO_BASE, 32'h0, 4'b1111);
        @(negedge clk); chk("tohost_zero_ignored", 32'(done), 32'h0);
        @(posedge clk); #1;
        wr(MMIO_BASE, 32'h2, 4'b1111);
        wr(MMIO_BASE, 32'h1, 4'b1111);
        d_mem_addr = MMIO_BASE;
        @(negedge clk);
        chk("tohost_done", 32'(done), 32'h1);
        chk("tohost_fail", 32'(pass), 32'h0);
        chk("tohost_val", tohost_val, 32'h2);
        chk("tohost_read", d_mem_rdata, 32'h2);
        @(posedge clk); #1;
        do_reset();
        @(negedge clk);
        chk("tohost_reset_done", 32'(done), 32'h0);
        chk("tohost_reset_val", tohost_val, 32'h0);
        @(posedge clk); #1;
        wr(MMIO_BASE, 32'h1, 4'b1111);
        @(negedge clk);
        chk("tohost_pass", 32'(pass), 32'h1);
        chk("tohost_pass_done", 32'(done), 32'h1);
        @(posedge clk); #1;

        idle(2);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
